// File: rtl/mp3_disp_core.sv
// mp3_disp_core: VGA pixel renderer for the MP3 player UI (album art, volume bar, button icons).
// The cursor overlay is built only when MP3_DISP_CURSOR_EN is defined.
module mp3_disp_core #(
    parameter int NUM_SONGS = 4,
    parameter int IMG_X0    = 80,
    parameter int IMG_Y0    = 320,
    parameter int IMG_W     = 128,
    parameter int IMG_H     = 64,
    parameter int VOL_X0    = 400,
    parameter int VOL_Y0    = 320,
    parameter int BTN_Y0    = 420,
    parameter int HL_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_next,
    input  logic        i_pre,
    input  logic        i_vol_plus,
    input  logic        i_vol_dec,
    input  logic [15:0] doutb,
    input  logic        i_vs,
    input  logic [3:0]  vol_level,
    input  logic        i_finish_song,
    input  logic [7:0]  alc_x,
    input  logic [7:0]  alc_y,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic [14:0] addrb
);
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int VOL_W     = 128;
    localparam int VOL_H     = 16;
    localparam int BTN_X0    = 80;
    localparam int BTN_PITCH = 50;
    localparam int BTN_SIZE  = 32;
    localparam int NUM_BTNS  = 4;
    localparam int SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
    localparam int HL_W      = $clog2(HL_FRAMES + 1);
    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_CURSOR = 12'hFFF;
    localparam logic [11:0] C_VOL_ON = 12'h0F0;
    localparam logic [11:0] C_VOL_OFF= 12'h333;
    localparam logic [11:0] C_BTN_HL = 12'hFF0;
    localparam logic [11:0] C_BTN    = 12'h888;
    localparam logic [11:0] C_BG     = 12'h003;

    logic next_q, pre_q, fin_q, vplus_q, vdec_q, vs_q;
    logic next_rise, pre_rise, fin_rise, vs_rise;
    logic [NUM_BTNS-1:0] press;
    logic [SONG_W-1:0] song_idx;
    logic [NUM_BTNS-1:0][HL_W-1:0] hl_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            {next_q, pre_q, fin_q, vplus_q, vdec_q, vs_q} <= '0;
        end else begin
            {next_q, pre_q, fin_q, vplus_q, vdec_q, vs_q} <=
                {i_next, i_pre, i_finish_song, i_vol_plus, i_vol_dec, i_vs};
        end
    end

    assign next_rise = i_next & ~next_q;
    assign pre_rise  = i_pre & ~pre_q;
    assign fin_rise  = i_finish_song & ~fin_q;
    assign vs_rise   = i_vs & ~vs_q;
    // Icon order on screen: pre, next, vol-, vol+.
    assign press = {i_vol_plus & ~vplus_q, i_vol_dec & ~vdec_q, next_rise, pre_rise};

    logic adv, back;
    assign adv  = next_rise | fin_rise;
    assign back = pre_rise;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            song_idx <= '0;
        end else if (adv && !back) begin
            song_idx <= (song_idx == LAST_SONG) ? '0 : song_idx + SONG_W'(1);
        end else if (back && !adv) begin
            song_idx <= (song_idx == '0) ? LAST_SONG : song_idx - SONG_W'(1);
        end
    end

    // A press reloads its counter even mid-count; frame ticks only drain it to zero.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hl_cnt <= '0;
        end else begin
            for (int b = 0; b < NUM_BTNS; b++) begin
                if (press[b]) begin
                    hl_cnt[b] <= HL_W'(HL_FRAMES);
                end else if (vs_rise && hl_cnt[b] != '0) begin
                    hl_cnt[b] <= hl_cnt[b] - HL_W'(1);
                end
            end
        end
    end

    logic in_active, in_img, in_vol, in_btn_row, in_btn, in_cursor, seg_lit, btn_lit;
    logic [15:0] img_dx, img_dy, vol_dx;
    logic [31:0] addr_full;
    logic unused_bits;

    assign in_active  = (i_x < 16'(H_ACTIVE)) && (i_y < 16'(V_ACTIVE));
    assign in_img     = (i_x >= 16'(IMG_X0)) && (i_x < 16'(IMG_X0 + IMG_W)) &&
                        (i_y >= 16'(IMG_Y0)) && (i_y < 16'(IMG_Y0 + IMG_H));
    assign in_vol     = (i_x >= 16'(VOL_X0)) && (i_x < 16'(VOL_X0 + VOL_W)) &&
                        (i_y >= 16'(VOL_Y0)) && (i_y < 16'(VOL_Y0 + VOL_H));
    assign in_btn_row = (i_y >= 16'(BTN_Y0)) && (i_y < 16'(BTN_Y0 + BTN_SIZE));

    assign img_dx    = i_x - 16'(IMG_X0);
    assign img_dy    = i_y - 16'(IMG_Y0);
    assign addr_full = 32'(song_idx) * 32'(IMG_W * IMG_H) + 32'(img_dy) * 32'(IMG_W) + 32'(img_dx);
    assign addrb     = in_img ? addr_full[14:0] : '0;

    assign vol_dx  = i_x - 16'(VOL_X0);
    assign seg_lit = vol_dx[6:3] < vol_level;

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        in_btn  = 1'b0;
        btn_lit = 1'b0;
        for (int b = 0; b < NUM_BTNS; b++) begin
            if (in_btn_row && i_x >= 16'(BTN_X0 + b * BTN_PITCH) &&
                i_x < 16'(BTN_X0 + b * BTN_PITCH + BTN_SIZE)) begin
                in_btn  = 1'b1;
                btn_lit = (hl_cnt[b] != '0);
            end
        end
    end

`ifdef MP3_DISP_CURSOR_EN
    logic [16:0] cur_x0, cur_y0;
    assign cur_x0    = {8'd0, alc_x, 1'b0};
    assign cur_y0    = {8'd0, alc_y, 1'b0};
    assign in_cursor = ({1'b0, i_x} >= cur_x0) && ({1'b0, i_x} < cur_x0 + 17'd8) &&
                       ({1'b0, i_y} >= cur_y0) && ({1'b0, i_y} < cur_y0 + 17'd8);
    assign unused_bits = ^{doutb[15:12], addr_full[31:15], vol_dx[15:7], vol_dx[2:0]};
`else
    assign in_cursor   = 1'b0;
    assign unused_bits = ^{doutb[15:12], addr_full[31:15], vol_dx[15:7], vol_dx[2:0], alc_x, alc_y};
`endif

    // Stage 1 resolves everything except the ROM pixel, which arrives one clock after addrb.
    logic        s1_rom, s1_rom_d;
    logic [11:0] s1_col, s1_col_d, rgb;

    always_comb begin
        s1_rom_d = 1'b0;
        s1_col_d = C_BG;
        if (!in_active)     s1_col_d = C_BLACK;
        else if (in_cursor) s1_col_d = C_CURSOR;
        else if (in_img)  begin s1_rom_d = 1'b1; s1_col_d = C_BLACK; end
        else if (in_vol)    s1_col_d = seg_lit ? C_VOL_ON : C_VOL_OFF;
        else if (in_btn)    s1_col_d = btn_lit ? C_BTN_HL : C_BTN;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1_rom <= 1'b0;
            s1_col <= '0;
            rgb    <= '0;
        end else begin
            s1_rom <= s1_rom_d;
            s1_col <= s1_col_d;
            rgb    <= s1_rom ? doutb[11:0] : s1_col;
        end
    end

    assign {o_red, o_green, o_blue} = rgb;
endmodule

// File: tb/tb_mp3_disp_core.sv
// tb_mp3_disp_core: randomized and directed checks of mp3_disp_core against a behavioural screen model.
// Build with MP3_DISP_CURSOR_EN defined to exercise the cursor layer.
module tb_mp3_disp_core;
    localparam int NUM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_x, i_y, doutb;
    logic        i_next, i_pre, i_vol_plus, i_vol_dec, i_vs, i_finish_song;
    logic [3:0]  vol_level;
    logic [7:0]  alc_x, alc_y;
    logic [3:0]  o_red, o_green, o_blue;
    logic [14:0] addrb;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: current track, highlight frames left per icon, previous input levels.
    int       m_song;
    int       m_hl[4];
    logic [5:0] m_prev;

    always #5 clk = ~clk;

    mp3_disp_core dut (
        .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_y(i_y),
        .i_next(i_next), .i_pre(i_pre), .i_vol_plus(i_vol_plus), .i_vol_dec(i_vol_dec),
        .doutb(doutb), .i_vs(i_vs), .vol_level(vol_level), .i_finish_song(i_finish_song),
        .alc_x(alc_x), .alc_y(alc_y),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .addrb(addrb)
    );

    // Synchronous image ROM with address-dependent content, upper nibble deliberately non-zero.
    function automatic logic [15:0] rom_word(input logic [14:0] a);
        return {a[3:0] ^ 4'h9, a[11:0] ^ {a[14:12], a[14:12], a[14:12], a[14:12]}};
    endfunction

    always @(posedge clk) doutb <= rom_word(addrb);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_rect(input int x, input int y, input int x0, input int y0,
                                   input int w, input int h);
        return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
    endfunction

    function automatic int model_addr(input int x, input int y);
        if (!in_rect(x, y, 80, 320, 128, 64)) return 0;
        return (m_song * 128 * 64 + (y - 320) * 128 + (x - 80)) % 32768;
    endfunction

    function automatic logic [11:0] exp_colour(input int x, input int y);
        logic [15:0] w;
        if (x >= 640 || y >= 480) return 12'h000;
`ifdef MP3_DISP_CURSOR_EN
        if (in_rect(x, y, 2 * int'(alc_x), 2 * int'(alc_y), 8, 8)) return 12'hFFF;
`endif
        if (in_rect(x, y, 80, 320, 128, 64)) begin
            w = rom_word(15'(model_addr(x, y)));
            return w[11:0];
        end
        if (in_rect(x, y, 400, 320, 128, 16))
            return ((x - 400) / 8 < int'(vol_level)) ? 12'h0F0 : 12'h333;
        for (int i = 0; i < 4; i++)
            if (in_rect(x, y, 80 + 50 * i, 420, 32, 32))
                return (m_hl[i] > 0) ? 12'hFF0 : 12'h888;
        return 12'h003;
    endfunction

    // Drive one cycle of event levels and apply the same edge rules to the model.
    task automatic apply_events(input bit nx, input bit pr, input bit fin,
                                input bit vp, input bit vd, input bit vs);
        bit r_nx, r_pr, r_fin, r_vp, r_vd, r_vs, adv, back;
        bit pressed[4];
        @(negedge clk);
        {i_next, i_pre, i_finish_song, i_vol_plus, i_vol_dec, i_vs} = {nx, pr, fin, vp, vd, vs};
        r_nx  = nx  && !m_prev[5];
        r_pr  = pr  && !m_prev[4];
        r_fin = fin && !m_prev[3];
        r_vp  = vp  && !m_prev[2];
        r_vd  = vd  && !m_prev[1];
        r_vs  = vs  && !m_prev[0];
        adv  = r_nx || r_fin;
        back = r_pr;
        if (adv && !back)      m_song = (m_song + 1) % NUM;
        else if (back && !adv) m_song = (m_song + NUM - 1) % NUM;
        pressed = '{r_pr, r_nx, r_vd, r_vp};
        for (int i = 0; i < 4; i++) begin
            if (pressed[i])             m_hl[i] = 8;
            else if (r_vs && m_hl[i] > 0) m_hl[i] = m_hl[i] - 1;
        end
        m_prev = {nx, pr, fin, vp, vd, vs};
        @(posedge clk);
    endtask

    task automatic pulse(input bit nx, input bit pr, input bit fin,
                         input bit vp, input bit vd, input bit vs);
        apply_events(nx, pr, fin, vp, vd, vs);
        apply_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Present a pixel for exactly one clock, then an off-screen pixel; the output two edges later
    // must belong to the first pixel.
    task automatic query(input string tag, input int x, input int y);
        logic [11:0] exp_c;
        logic [14:0] exp_a;
        @(negedge clk);
        i_x = 16'(x);
        i_y = 16'(y);
        exp_a = 15'(model_addr(x, y));
        exp_c = exp_colour(x, y);
        #1 check({tag, " addrb"}, 32'(addrb), 32'(exp_a));
        @(posedge clk);
        @(negedge clk);
        i_x = 16'hFFFF;
        i_y = 16'hFFFF;
        @(posedge clk);
        #1 check({tag, " rgb"}, 32'({o_red, o_green, o_blue}), 32'(exp_c));
    endtask

    task automatic addr_at_origin(input string tag, input int exp);
        @(negedge clk);
        i_x = 16'd80;
        i_y = 16'd320;
        #1 check(tag, 32'(addrb), 32'(exp));
    endtask

    initial begin
        int x, y, base, r;
        m_song = 0;
        m_hl   = '{0, 0, 0, 0};
        m_prev = '0;
        {i_next, i_pre, i_finish_song, i_vol_plus, i_vol_dec, i_vs} = '0;
        i_x = 16'd0; i_y = 16'd0;
        vol_level = 4'd0; alc_x = 8'd0; alc_y = 8'd0;

        // Reset: held two clocks at a background pixel, outputs must stay black.
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset rgb", 32'({o_red, o_green, o_blue}), 32'h000);
        check("reset addrb", 32'(addrb), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        addr_at_origin("reset song0", 0);
        query("bg origin", 0, 0);

        // Album art sweep on row 350 for track 0, crossing the right edge.
        for (int xs = 80; xs <= 210; xs += 5) query("art sweep", xs, 350);

        // Track stepping with wrap and simultaneous requests.
        pulse(1, 0, 0, 0, 0, 0); addr_at_origin("next1", 8192);
        pulse(1, 0, 0, 0, 0, 0); addr_at_origin("next2", 16384);
        pulse(1, 0, 0, 0, 0, 0); addr_at_origin("next3", 24576);
        pulse(0, 1, 0, 0, 0, 0); addr_at_origin("pre1", 16384);
        pulse(1, 1, 0, 0, 0, 0); addr_at_origin("next+pre", 16384);
        pulse(1, 0, 0, 0, 0, 0); addr_at_origin("to3", 24576);
        pulse(1, 0, 0, 0, 0, 0); addr_at_origin("wrap3to0", 0);
        pulse(0, 1, 0, 0, 0, 0); addr_at_origin("wrap0to3", 24576);
        pulse(0, 0, 1, 0, 0, 0); addr_at_origin("finish", 0);
        apply_events(1, 0, 0, 0, 0, 0);
        repeat (3) apply_events(1, 0, 0, 0, 0, 0);
        addr_at_origin("next held", 8192);
        apply_events(0, 0, 0, 0, 0, 0);
        query("art track1", 207, 383);

        // Volume bar at levels 5, 0 and 15.
        vol_level = 4'd5;
        for (int xs = 398; xs <= 529; xs += 3) query("vol5", xs, 328);
        query("vol5 seg4 end", 439, 328);
        query("vol5 seg5 start", 440, 328);
        vol_level = 4'd0;
        query("vol0 seg0", 400, 320);
        query("vol0 seg15", 527, 335);
        vol_level = 4'd15;
        query("vol15 seg14", 519, 328);
        query("vol15 seg15", 520, 328);

        // Drain highlights left over from track tests, then exercise vol+ flash.
        repeat (8) pulse(0, 0, 0, 0, 0, 1);
        query("pre icon idle", 80, 420);
        pulse(0, 0, 0, 1, 0, 0);
        query("vol+ flash", 232, 430);
        repeat (7) pulse(0, 0, 0, 0, 0, 1);
        query("vol+ after 7", 232, 430);
        pulse(0, 0, 0, 0, 0, 1);
        query("vol+ after 8", 232, 430);
        apply_events(0, 0, 0, 1, 0, 0);
        for (int f = 0; f < 8; f++) begin
            apply_events(0, 0, 0, 1, 0, 1);
            apply_events(0, 0, 0, 1, 0, 0);
        end
        query("vol+ held", 232, 430);
        apply_events(0, 0, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 1, 0);
        query("vol- flash", 211, 451);
        query("gap between icons", 120, 430);

        // Cursor overlay (or plain background when the layer is not built).
        alc_x = 8'hFC;
        alc_y = 8'd175;
        query("cursor tl", 504, 350);
        query("cursor br", 511, 357);
        query("cursor right", 512, 350);
        query("off-screen x640", 640, 10);
        query("off-screen y480", 10, 480);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            for (int c = 0; c < int'($urandom_range(1, 4)); c++)
                apply_events($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) vol_level = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                alc_x = 8'($urandom_range(0, 255));
                alc_y = 8'($urandom_range(0, 255));
            end
            r = int'($urandom_range(0, 5));
            case (r)
                0: begin x = int'($urandom_range(76, 211)); y = int'($urandom_range(316, 387)); end
                1: begin x = int'($urandom_range(396, 531)); y = int'($urandom_range(316, 339)); end
                2: begin x = int'($urandom_range(76, 265)); y = int'($urandom_range(416, 455)); end
                3: begin
                    base = 2 * int'(alc_x);
                    x = (base > 0 ? base - 1 : 0) + int'($urandom_range(0, 9));
                    base = 2 * int'(alc_y);
                    y = (base > 0 ? base - 1 : 0) + int'($urandom_range(0, 9));
                end
                4: begin x = int'($urandom_range(0, 700)); y = int'($urandom_range(0, 520)); end
                default: begin x = int'($urandom_range(0, 65535)); y = int'($urandom_range(0, 65535)); end
            endcase
            query("random", x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
